// File: rtl/laser_scorer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | laser_scorer: double-buffered point capture and two-circle coverage score |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
module laser_scorer #(
  parameter int NPTS  = 40,
  parameter int LANES = 4,
  parameter int R2    = 16
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic [3:0] X,
  input  logic [3:0] Y,
  input  logic [3:0] C1X,
  input  logic [3:0] C1Y,
  input  logic [3:0] C2X,
  input  logic [3:0] C2Y,
  input  logic       DONE,
  output logic [5:0] SCORE,
  output logic       SCORE_VALID,
  output logic [5:0] BEST_SCORE,
  output logic [7:0] RUN_CNT,
  output logic       ERR
);

  localparam int G     = (NPTS + LANES - 1) / LANES;
  localparam int NSLOT = G * LANES;
  localparam int IW    = (NSLOT > 1) ? $clog2(NSLOT) : 1;
  localparam int CW    = $clog2(NPTS + 1);
  localparam int GW    = (G > 1) ? $clog2(G) : 1;
  localparam int HW    = $clog2(LANES + 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SCORE  = 2'd1,
    S_REPORT = 2'd2
  } state_t;

  state_t           state;
  logic [3:0]       bank_x [2][NSLOT];
  logic [3:0]       bank_y [2][NSLOT];
  logic             cap_bank;
  logic [CW-1:0]    cap_cnt;
  logic             cap_full;
  logic             score_bank;
  logic [GW-1:0]    grp;
  logic [5:0]       acc;
  logic [3:0]       c1x_q, c1y_q, c2x_q, c2y_q;
  logic [IW-1:0]    idx;
  logic [HW-1:0]    hits;

  assign cap_full   = (cap_cnt == CW'(NPTS));
  assign score_bank = ~cap_bank;

  function automatic logic covered(input logic [3:0] px, input logic [3:0] py,
                                   input logic [3:0] cx, input logic [3:0] cy);
    logic [3:0] dx;
    logic [3:0] dy;
    logic [8:0] d2;
    dx = (px >= cx) ? (px - cx) : (cx - px);
    dy = (py >= cy) ? (py - cy) : (cy - py);
    d2 = 9'(dx) * 9'(dx) + 9'(dy) * 9'(dy);
    return d2 <= 9'(R2);
  endfunction

  // Padding lanes past the last real point never count.
  always_comb begin
    hits = '0;
    idx  = '0;
    for (int l = 0; l < LANES; l++) begin
      idx = IW'(grp) * IW'(LANES) + IW'(l);
      if ((int'(idx) < NPTS) &&
          (covered(bank_x[score_bank][idx], bank_y[score_bank][idx], c1x_q, c1y_q) ||
           covered(bank_x[score_bank][idx], bank_y[score_bank][idx], c2x_q, c2y_q)))
        hits = hits + HW'(1);
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      bank_x      <= '{default: '0};
      bank_y      <= '{default: '0};
      cap_bank    <= 1'b0;
      cap_cnt     <= '0;
      state       <= S_IDLE;
      grp         <= '0;
      acc         <= '0;
      c1x_q       <= '0;
      c1y_q       <= '0;
      c2x_q       <= '0;
      c2y_q       <= '0;
      SCORE       <= '0;
      SCORE_VALID <= 1'b0;
      BEST_SCORE  <= '0;
      RUN_CNT     <= '0;
      ERR         <= 1'b0;
    end else begin
      SCORE_VALID <= 1'b0;

      if (DONE && state == S_IDLE) begin
        if (cap_full) begin
          c1x_q    <= C1X;
          c1y_q    <= C1Y;
          c2x_q    <= C2X;
          c2y_q    <= C2Y;
          cap_bank <= ~cap_bank;
          cap_cnt  <= '0;
          grp      <= '0;
          acc      <= '0;
          state    <= S_SCORE;
        end else begin
          // Short set: drop it and refill the same bank from index 0.
          ERR     <= 1'b1;
          cap_cnt <= '0;
        end
      end else begin
        if (DONE)
          ERR <= 1'b1;
        if (!cap_full) begin
          bank_x[cap_bank][IW'(cap_cnt)] <= X;
          bank_y[cap_bank][IW'(cap_cnt)] <= Y;
          cap_cnt <= cap_cnt + CW'(1);
        end
      end

      case (state)
        S_SCORE: begin
          acc <= acc + 6'(hits);
          grp <= grp + GW'(1);
          if (grp == GW'(G - 1))
            state <= S_REPORT;
        end
        S_REPORT: begin
          SCORE       <= acc;
          SCORE_VALID <= 1'b1;
          if (acc > BEST_SCORE)
            BEST_SCORE <= acc;
          RUN_CNT     <= RUN_CNT + 8'd1;
          state       <= S_IDLE;
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_laser_scorer.sv
`default_nettype none
// tb_laser_scorer: table-driven back-to-back scoring runs plus hand-written
// reset, spurious-DONE and short-set sequences.
module tb_laser_scorer;

  localparam int NPTS = 40;

  logic       CLK = 1'b0;
  logic       RST;
  logic [3:0] X, Y, C1X, C1Y, C2X, C2Y;
  logic       DONE;
  logic [5:0] SCORE, BEST_SCORE;
  logic       SCORE_VALID, ERR;
  logic [7:0] RUN_CNT;

  laser_scorer dut (
    .CLK(CLK), .RST(RST), .X(X), .Y(Y),
    .C1X(C1X), .C1Y(C1Y), .C2X(C2X), .C2Y(C2Y), .DONE(DONE),
    .SCORE(SCORE), .SCORE_VALID(SCORE_VALID), .BEST_SCORE(BEST_SCORE),
    .RUN_CNT(RUN_CNT), .ERR(ERR)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  typedef struct {
    int cyc;
    int score;
    int best;
    int run;
  } pulse_t;
  pulse_t q[$];

  always @(negedge CLK)
    if (SCORE_VALID === 1'b1)
      q.push_back('{cyc, int'(SCORE), int'(BEST_SCORE), int'(RUN_CNT)});

  typedef struct {
    int c1x, c1y, c2x, c2y;
    int px, py, n, fx, fy;
    int exp_score;
  } vec_t;

  int tests = 0;
  int fails = 0;

  task automatic chk(input string nm, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_score"},       int'(SCORE), 0);
    chk({tag, "_score_valid"}, int'(SCORE_VALID), 0);
    chk({tag, "_best"},        int'(BEST_SCORE), 0);
    chk({tag, "_run_cnt"},     int'(RUN_CNT), 0);
    chk({tag, "_err"},         int'(ERR), 0);
  endtask

  task automatic put(input int x, input int y);
    X = 4'(x);
    Y = 4'(y);
    @(posedge CLK);
    #1;
  endtask

  task automatic put_d(input int x, input int y, input int a, input int b,
                       input int c, input int d);
    C1X = 4'(a); C1Y = 4'(b); C2X = 4'(c); C2Y = 4'(d);
    DONE = 1'b1;
    put(x, y);
    DONE = 1'b0;
  endtask

  task automatic do_done(input int a, input int b, input int c, input int d,
                         output int dc);
    put_d(0, 0, a, b, c, d);
    dc = cyc;
  endtask

  task automatic stream(input int px, input int py, input int n,
                        input int fx, input int fy);
    for (int i = 0; i < NPTS; i++)
      if (i < n) put(px, py);
      else       put(fx, fy);
  endtask

  task automatic expect_pulse(input string nm, input int es, input int eb,
                              input int er, input int dc);
    pulse_t p;
    int t;
    t = 0;
    while (q.size() == 0 && t < 60) begin
      @(posedge CLK);
      #1;
      t++;
    end
    if (q.size() == 0) begin
      tests++;
      fails++;
      $display("FAIL %s_timeout: got no SCORE_VALID, expected one", nm);
    end else begin
      p = q.pop_front();
      chk({nm, "_score"},   p.score, es);
      chk({nm, "_best"},    p.best, eb);
      chk({nm, "_run_cnt"}, p.run, er);
      chk({nm, "_latency"}, p.cyc - dc, 11);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish, expected finish");
    $fatal(1, "watchdog");
  end

  vec_t tbl[13];
  int   dcs[13];
  int   best_m;
  int   dc_a, dc_b, dc_x;
  int   bx[8];
  int   by[8];

  initial begin
    //            c1x c1y c2x c2y  px  py   n  fx fy  exp
    tbl[0]  = '{  8,  8,  0,  0,  8,  8, 40,  0, 0, 40};
    tbl[1]  = '{  8,  8,  0, 15, 12,  8,  1, 15, 0,  1};
    tbl[2]  = '{  8,  8,  0, 15,  8, 12,  1, 15, 0,  1};
    tbl[3]  = '{  8,  8,  0, 15, 10, 11,  1, 15, 0,  1};
    tbl[4]  = '{  8,  8,  0, 15, 11, 10,  1, 15, 0,  1};
    tbl[5]  = '{  8,  8,  0, 15, 11, 11,  1, 15, 0,  0};
    tbl[6]  = '{  8,  8,  0, 15,  9, 12,  1, 15, 0,  0};
    tbl[7]  = '{  8,  8,  0, 15, 12,  9,  1, 15, 0,  0};
    tbl[8]  = '{  8,  8,  0, 15, 13,  8,  1, 15, 0,  0};
    tbl[9]  = '{  8,  8,  0, 15,  4,  8,  1, 15, 0,  1};
    tbl[10] = '{  6,  6,  8,  6,  7,  6, 10,  0, 0, 10};
    tbl[11] = '{  0,  0, 15, 15, 15, 15, 40,  0, 8, 40};
    tbl[12] = '{  0,  0, 15, 15, 14, 13, 12,  0, 8, 12};

    bx = '{12,  8, 10, 11, 11,  9, 12, 13};
    by = '{ 8, 12, 11, 10, 11, 12,  9,  8};

    RST = 1'b1; DONE = 1'b0;
    X = '0; Y = '0; C1X = '0; C1Y = '0; C2X = '0; C2Y = '0;
    repeat (3) @(posedge CLK);
    #1;
    chk_zero("reset");
    RST = 1'b0;

    // Each set streams starting the cycle after the previous DONE.
    for (int i = 0; i < 13; i++) begin
      stream(tbl[i].px, tbl[i].py, tbl[i].n, tbl[i].fx, tbl[i].fy);
      do_done(tbl[i].c1x, tbl[i].c1y, tbl[i].c2x, tbl[i].c2y, dcs[i]);
    end
    best_m = 0;
    for (int i = 0; i < 13; i++) begin
      if (tbl[i].exp_score > best_m) best_m = tbl[i].exp_score;
      expect_pulse($sformatf("vec%0d", i), tbl[i].exp_score, best_m, i + 1, dcs[i]);
    end
    chk("table_extra_pulses", q.size(), 0);
    chk("table_err", int'(ERR), 0);

    // Reset in the middle of capturing junk after the last run.
    repeat (5) put(3, 3);
    RST = 1'b1;
    #1;
    chk_zero("mid_reset");
    @(posedge CLK);
    #1;
    RST = 1'b0;

    // Radius boundary set, then a spurious DONE while it is being scored.
    for (int i = 0; i < NPTS; i++)
      if (i < 8) put(bx[i], by[i]);
      else       put(15, 0);
    do_done(8, 8, 0, 15, dc_a);
    for (int i = 0; i < NPTS; i++) begin
      if (i == 2) begin
        put_d(8, 8, 15, 0, 15, 0);
        chk("spurious_done_err", int'(ERR), 1);
      end else begin
        put(8, 8);
      end
    end
    do_done(8, 8, 0, 0, dc_b);
    expect_pulse("boundary", 4, 4, 1, dc_a);
    expect_pulse("after_spurious", 40, 40, 2, dc_b);
    chk("spurious_extra_pulses", q.size(), 0);

    // Short set: DONE after 20 points, then a full set.
    RST = 1'b1;
    @(posedge CLK);
    #1;
    RST = 1'b0;
    repeat (20) put(1, 1);
    do_done(1, 1, 1, 1, dc_x);
    chk("early_done_err", int'(ERR), 1);
    stream(14, 13, 12, 0, 8);
    do_done(0, 0, 15, 15, dc_x);
    expect_pulse("after_early", 12, 12, 1, dc_x);
    chk("early_extra_pulses", q.size(), 0);
    chk("early_err_sticky", int'(ERR), 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
